mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 4:1 single-bit mux (4 data bits, 2-bit select) between four requesters.

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types for the round-robin 4:1 mux arbiter.
// Optional hold limit enabled by defining ARB_HOLD_LIMIT_EN.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic req_vec_t onehot(
    input sel_t i
  );
    return req_vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first set bit
// searching ptr+1, ptr+2, ... ptr (mod 4).
module rr_pick4
  import mux_arb_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  output logic     found,
  output sel_t     idx
);

  sel_t cand;

  // Walk farthest-first so the nearest hit wins last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux.
// Define ARB_HOLD_LIMIT_EN to cap an owner's tenure at MAX_HOLD cycles.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = $clog2(MAX_HOLD) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             gnt_valid
);

  arb_state_t state_q, state_d;
  req_vec_t   gnt_q, gnt_d;
  sel_t       sel_q, sel_d;
  sel_t       ptr_q, ptr_d;

  req_vec_t masked;
  logic     found;
  sel_t     pick_idx;
  logic     owner_req;
  logic     expire;
  logic     keep;
  logic     take;

  // Owner is masked out, so a hit means someone else is waiting.
  assign masked    = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);

  rr_pick4 u_pick (
    .req   (masked),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign expire = (hold_cnt_q == HOLD_LAST) && found;

  // Saturates at the last slot so a late waiter rotates in at once.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (take || !keep) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  // Lock mode: tenure never expires.
  assign expire = (CNT_W < 1);
`endif

  assign keep = (state_q == GRANT) && owner_req && !expire;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        take = found;
      end
      GRANT: begin
        if (!keep) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (take) begin
      state_d = GRANT;
      gnt_d   = onehot(pick_idx);
      sel_d   = pick_idx;
      ptr_d   = pick_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= sel_t'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus
// hand sequences for hold limit and async reset.
module tb_mux4_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       gnt_valid;

  int n_chk = 0;
  int n_err = 0;

  mux4_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Structural invariants on every cycle.
  always @(negedge clk) begin
    n_chk++;
    if (!(gnt == 4'b0000 || $onehot(gnt))) begin
      n_err++;
      $display("FAIL onehot: gnt=%b", gnt);
    end
    n_chk++;
    if (gnt_valid !== (gnt != 4'b0000)) begin
      n_err++;
      $display("FAIL valid_eq: gnt_valid=%b gnt=%b", gnt_valid, gnt);
    end
    if (gnt_valid) begin
      n_chk++;
      if (gnt !== (4'b0001 << sel)) begin
        n_err++;
        $display("FAIL sel_idx: sel=%0d gnt=%b", sel, gnt);
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  int wait_cnt[4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || !req[i] || gnt[i]) begin
        wait_cnt[i] = 0;
      end else begin
        wait_cnt[i]++;
      end
      n_chk++;
      if (wait_cnt[i] > 3 * MAX_HOLD + 1) begin
        n_err++;
        $display("FAIL starve: req %0d waited %0d", i, wait_cnt[i]);
      end
    end
  end
`endif

  initial begin
    logic [3:0] exp_g;

    tbl[0]  = '{4'b1111, 4'b0001, 2'd0, 1'b1};
    tbl[1]  = '{4'b1110, 4'b0010, 2'd1, 1'b1};
    tbl[2]  = '{4'b1100, 4'b0100, 2'd2, 1'b1};
    tbl[3]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[4]  = '{4'b0111, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[7]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[8]  = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    tbl[9]  = '{4'b0101, 4'b0001, 2'd0, 1'b1};
    tbl[10] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
    tbl[11] = '{4'b0101, 4'b0100, 2'd2, 1'b1};
    tbl[12] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[14] = '{4'b0010, 4'b0010, 2'd1, 1'b1};

    // T1: reset holds outputs clear despite requests
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_vld", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // T2/T3 and rotation cases from the table
    for (int i = 0; i < 15; i++) begin
      req = tbl[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("v%0d_vld", i), 32'(gnt_valid), 32'(tbl[i].vld));
      @(negedge clk);
    end

    // T4: two requesters held continuously
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
`ifdef ARB_HOLD_LIMIT_EN
      exp_g = (((c / MAX_HOLD) % 2) == 1) ? 4'b0010 : 4'b0001;
`else
      exp_g = 4'b0001;
`endif
      chk($sformatf("hold_c%0d", c), 32'(gnt), 32'(exp_g));
      @(negedge clk);
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Saturated counter: late waiter takes over on the next edge
    do_reset();
    req = 4'b0001;
    repeat (6) @(posedge clk);
    #1;
    chk("sat_own", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'b0011;
    @(posedge clk);
    #1;
    chk("sat_rot", 32'(gnt), 32'h2);
    @(negedge clk);
`endif

    // T5: async reset mid-grant
    do_reset();
    req = 4'b0100;
    @(posedge clk);
    #1;
    chk("t5_pre", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_gnt0", 32'(gnt), 32'h0);
    chk("t5_vld0", 32'(gnt_valid), 32'h0);
    chk("t5_sel0", 32'(sel), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_regnt", 32'(gnt), 32'h4);
    chk("t5_resel", 32'(sel), 32'h2);

    // Pointer back at 3 after reset: 2 beats 3 in the search
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1100;
    @(posedge clk);
    #1;
    chk("t5_ptr", 32'(gnt), 32'h4);
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
